// File: rtl/systolic_tile_scheduler.sv
// Tile scheduler for the systolic array: walks a K_TILES x N_TILES weight grid
// (K inner), drives the controller load/compute handshake and weight-buffer reads.
module systolic_tile_scheduler #(
    parameter int N_SIZE     = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int TILE_CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TILE_CNT_W-1:0] k_tiles,
    input  logic [TILE_CNT_W-1:0] n_tiles,
    input  logic                  ctrl_ready,
    input  logic                  ctrl_done,
    output logic                  load_weight,
    output logic                  valid_in,
    output logic                  wt_rd_en,
    output logic [ADDR_WIDTH-1:0] wt_rd_addr,
    output logic [TILE_CNT_W-1:0] k_idx,
    output logic [TILE_CNT_W-1:0] n_idx,
    output logic                  acc_en,
    output logic                  busy,
    output logic                  done
);

    localparam int ROW_W = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;
    localparam logic [ROW_W-1:0]      ROW_LAST    = ROW_W'(N_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] TILE_STRIDE = ADDR_WIDTH'(N_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WT,
        S_WAIT_RDY,
        S_COMPUTE,
        S_WAIT_IDLE,
        S_DONE
    } state_e;

    state_e                  state_q,     state_d;
    logic [ROW_W-1:0]        row_cnt_q,   row_cnt_d;
    logic [ADDR_WIDTH-1:0]   tile_base_q, tile_base_d;
    logic [TILE_CNT_W-1:0]   k_idx_q,     k_idx_d;
    logic [TILE_CNT_W-1:0]   n_idx_q,     n_idx_d;
    logic [TILE_CNT_W-1:0]   k_tiles_q,   k_tiles_d;
    logic [TILE_CNT_W-1:0]   n_tiles_q,   n_tiles_d;

    logic last_k;
    logic last_n;

    assign last_k = (k_idx_q == k_tiles_q - TILE_CNT_W'(1));
    assign last_n = (n_idx_q == n_tiles_q - TILE_CNT_W'(1));

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first so
        // no path through the case below can leave one unassigned (no latches).
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        tile_base_d = tile_base_q;
        k_idx_d     = k_idx_q;
        n_idx_d     = n_idx_q;
        k_tiles_d   = k_tiles_q;
        n_tiles_d   = n_tiles_q;

        if (state_q != S_IDLE && abort) begin
            state_d     = S_IDLE;
            row_cnt_d   = '0;
            tile_base_d = '0;
            k_idx_d     = '0;
            n_idx_d     = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // abort beats a coincident start even though IDLE has nothing to cancel
                    if (start && !abort) begin
                        k_tiles_d   = k_tiles;
                        n_tiles_d   = n_tiles;
                        row_cnt_d   = '0;
                        tile_base_d = '0;
                        k_idx_d     = '0;
                        n_idx_d     = '0;
                        state_d     = (k_tiles == '0 || n_tiles == '0) ? S_DONE : S_LOAD_WT;
                    end
                end
                S_LOAD_WT: begin
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d = '0;
                        state_d   = S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (ctrl_ready) state_d = S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (ctrl_done) state_d = S_WAIT_IDLE;
                end
                S_WAIT_IDLE: begin
                    if (ctrl_ready) begin
                        tile_base_d = tile_base_q + TILE_STRIDE;
                        if (last_k && last_n) begin
                            k_idx_d = '0;
                            n_idx_d = '0;
                            state_d = S_DONE;
                        end else if (last_k) begin
                            k_idx_d = '0;
                            n_idx_d = n_idx_q + TILE_CNT_W'(1);
                            state_d = S_LOAD_WT;
                        end else begin
                            k_idx_d = k_idx_q + TILE_CNT_W'(1);
                            state_d = S_LOAD_WT;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update
    // together from values sampled at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_cnt_q   <= '0;
            tile_base_q <= '0;
            k_idx_q     <= '0;
            n_idx_q     <= '0;
            k_tiles_q   <= '0;
            n_tiles_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            tile_base_q <= tile_base_d;
            k_idx_q     <= k_idx_d;
            n_idx_q     <= n_idx_d;
            k_tiles_q   <= k_tiles_d;
            n_tiles_q   <= n_tiles_d;
        end
    end

    // Outputs depend only on registered state; address wraps modulo 2^ADDR_WIDTH.
    assign load_weight = (state_q == S_LOAD_WT);
    assign wt_rd_en    = (state_q == S_LOAD_WT);
    assign wt_rd_addr  = (state_q == S_LOAD_WT) ? tile_base_q + ADDR_WIDTH'(row_cnt_q) : '0;
    assign valid_in    = (state_q == S_COMPUTE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign k_idx       = k_idx_q;
    assign n_idx       = n_idx_q;
    assign acc_en      = (k_idx_q != '0);

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Directed bench for systolic_tile_scheduler at N_SIZE=4; a second instance
// with ADDR_WIDTH=4 shares the stimulus to exercise address wrap.
module tb_systolic_tile_scheduler;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ctrl_ready = 1'b1;
    logic       ctrl_done = 1'b0;
    logic [5:0] k_tiles = '0;
    logic [5:0] n_tiles = '0;

    logic        load_weight, valid_in, wt_rd_en, acc_en, busy, done;
    logic [15:0] wt_rd_addr;
    logic [5:0]  k_idx, n_idx;

    logic        w_load_weight, w_valid_in, w_wt_rd_en, w_acc_en, w_busy, w_done;
    logic [3:0]  w_wt_rd_addr;
    logic [5:0]  w_k_idx, w_n_idx;

    int checks = 0;
    int errors = 0;

    systolic_tile_scheduler #(.N_SIZE(N), .ADDR_WIDTH(16), .TILE_CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .k_tiles(k_tiles), .n_tiles(n_tiles),
        .ctrl_ready(ctrl_ready), .ctrl_done(ctrl_done),
        .load_weight(load_weight), .valid_in(valid_in), .wt_rd_en(wt_rd_en),
        .wt_rd_addr(wt_rd_addr), .k_idx(k_idx), .n_idx(n_idx),
        .acc_en(acc_en), .busy(busy), .done(done)
    );

    systolic_tile_scheduler #(.N_SIZE(N), .ADDR_WIDTH(4), .TILE_CNT_W(6)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .k_tiles(k_tiles), .n_tiles(n_tiles),
        .ctrl_ready(ctrl_ready), .ctrl_done(ctrl_done),
        .load_weight(w_load_weight), .valid_in(w_valid_in), .wt_rd_en(w_wt_rd_en),
        .wt_rd_addr(w_wt_rd_addr), .k_idx(w_k_idx), .n_idx(w_n_idx),
        .acc_en(w_acc_en), .busy(w_busy), .done(w_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_lw"},    32'(load_weight), 0);
        check({tag, "_vi"},    32'(valid_in),    0);
        check({tag, "_rden"},  32'(wt_rd_en),    0);
        check({tag, "_addr"},  32'(wt_rd_addr),  0);
        check({tag, "_kidx"},  32'(k_idx),       0);
        check({tag, "_nidx"},  32'(n_idx),       0);
        check({tag, "_acc"},   32'(acc_en),      0);
        check({tag, "_busy"},  32'(busy),        0);
        check({tag, "_done"},  32'(done),        0);
    endtask

    task automatic start_job(input int k, input int n);
        k_tiles = 6'(k);
        n_tiles = 6'(n);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic finish_job(input string tag);
        check({tag, "_done"},  32'(done),        1);
        check({tag, "_busy"},  32'(busy),        1);
        check({tag, "_lw"},    32'(load_weight), 0);
        check({tag, "_vi"},    32'(valid_in),    0);
        tick();
        check({tag, "_done_after"}, 32'(done), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    // Entered in the first LOAD_WT cycle of a tile; leaves just after WAIT_IDLE.
    task automatic do_tile(input int k, input int n, input int base, input int rdy_delay,
                           input bit abort_mid, input bit poke_start);
        logic exp_acc;
        exp_acc = (k != 0);
        if (rdy_delay > 0) ctrl_ready = 1'b0;
        for (int r = 0; r < N; r++) begin
            check("load_lw",   32'(load_weight), 1);
            check("load_rden", 32'(wt_rd_en),    1);
            check("load_addr", 32'(wt_rd_addr),  (base + r) & 32'hFFFF);
            check("wrap_addr", 32'(w_wt_rd_addr), (base + r) & 32'hF);
            check("load_kidx", 32'(k_idx),       k);
            check("load_nidx", 32'(n_idx),       n);
            check("load_acc",  32'(acc_en),      32'(exp_acc));
            check("load_vi",   32'(valid_in),    0);
            check("load_busy", 32'(busy),        1);
            if (poke_start && r == 0) begin
                start   = 1'b1;
                k_tiles = 6'd7;
                n_tiles = 6'd7;
            end
            tick();
            start = 1'b0;
        end
        check("wrdy_lw",  32'(load_weight), 0);
        check("wrdy_acc", 32'(acc_en),      32'(exp_acc));
        for (int i = 0; i < rdy_delay; i++) begin
            check("wrdy_vi_held", 32'(valid_in), 0);
            tick();
        end
        ctrl_ready = 1'b1;
        check("wrdy_vi", 32'(valid_in), 0);
        tick();
        ctrl_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("comp_vi",  32'(valid_in), 1);
            check("comp_acc", 32'(acc_en),   32'(exp_acc));
            check("comp_kn",  32'({k_idx, n_idx}), 32'({6'(k), 6'(n)}));
            if (abort_mid && i == 2) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check_idle("abort");
                ctrl_ready = 1'b1;
                return;
            end
            tick();
        end
        check("comp_vi_last", 32'(valid_in), 1);
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        check("widl_vi",   32'(valid_in), 0);
        check("widl_busy", 32'(busy),     1);
        check("widl_acc",  32'(acc_en),   32'(exp_acc));
        ctrl_ready = 1'b1;
        tick();
    endtask

    initial begin
        #12;
        check_idle("reset");
        rst_n = 1'b1;
        tick();

        // Single tile job
        start_job(1, 1);
        do_tile(0, 0, 0, 0, 0, 0);
        finish_job("single");

        // 3x2 job, K inner loop
        start_job(3, 2);
        for (int t = 0; t < 6; t++) do_tile(t % 3, t / 3, t * N, 0, 0, 0);
        finish_job("grid");

        // Zero-count job
        start_job(0, 5);
        finish_job("zero");
        for (int i = 0; i < 5; i++) begin
            check("zero_lw", 32'(load_weight), 0);
            check("zero_vi", 32'(valid_in),    0);
            tick();
        end

        // Controller slow to become ready
        start_job(1, 1);
        do_tile(0, 0, 0, 10, 0, 0);
        finish_job("slow_rdy");

        // Abort on the third tile of four, then restart
        start_job(2, 2);
        do_tile(0, 0, 0, 0, 0, 0);
        do_tile(1, 0, 4, 0, 0, 0);
        do_tile(0, 1, 8, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            check("post_abort_done", 32'(done), 0);
            check("post_abort_busy", 32'(busy), 0);
            tick();
        end
        start_job(1, 1);
        do_tile(0, 0, 0, 0, 0, 0);
        finish_job("restart");

        // abort and start together in IDLE
        k_tiles = 6'd1;
        n_tiles = 6'd1;
        start   = 1'b1;
        abort   = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("abort_start");

        // Asynchronous reset during LOAD_WT
        start_job(2, 1);
        tick();
        tick();
        check("pre_rst_lw", 32'(load_weight), 1);
        #2 rst_n = 1'b0;
        #1 check_idle("rst_mid");
        #2 rst_n = 1'b1;
        tick();
        check_idle("rst_after");

        // start while busy is ignored
        start_job(1, 1);
        do_tile(0, 0, 0, 0, 0, 1);
        finish_job("busy_start");
        tick();
        check("busy_start_idle", 32'(busy), 0);

        // Address wrap: bases 0,4,8,12,0 on the 4-bit instance
        start_job(5, 1);
        for (int t = 0; t < 5; t++) do_tile(t, 0, t * N, 0, 0, 0);
        finish_job("wrap");
        check("wrap_done_w", 32'(w_done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
